// File: rtl/rs_issue_queue_pkg.sv
// ============================================================================
// Module  : rs_issue_queue_pkg
// Brief   : Shared defaults and ALU opcode encodings for the ALU reservation
//           station and its neighbours.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_issue_queue_pkg;

  localparam int RS_SIZE_DEF  = 8;
  localparam int RS_ADDR_DEF  = 3;
  localparam int ROB_ADDR_DEF = 4;
  localparam int XLEN_DEF     = 32;
  localparam int OP_W_DEF     = 6;

  // ALU opcode encodings shared with the decoder and the ALU
  typedef enum logic [OP_W_DEF-1:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_AND  = 6'd2,
    ALU_OR   = 6'd3,
    ALU_XOR  = 6'd4,
    ALU_SLL  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_SLT  = 6'd8,
    ALU_SLTU = 6'd9
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/rs_prio_pick.sv
// ============================================================================
// Module  : rs_prio_pick
// Brief   : Lowest-index priority encoder: request vector -> valid + index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] idx
);

  assign valid = |req;

  // scan from the top so the lowest set request is the last (winning) write
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rs_issue_queue.sv
// ============================================================================
// Module  : rs_issue_queue
// Brief   : ALU reservation station. Buffers decoded ops, tracks RoB-tagged
//           operand dependencies, wakes on CDB broadcast (with same-cycle
//           allocate bypass) and issues one ready op per cycle to the ALU.
//           Optional macro RS_AGE_ORDER_EN: oldest-first issue through an
//           age matrix; otherwise the lowest-index ready entry wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_issue_queue
  import rs_issue_queue_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DEF,
  parameter int RS_ADDR  = RS_ADDR_DEF,
  parameter int ROB_ADDR = ROB_ADDR_DEF,
  parameter int XLEN     = XLEN_DEF,
  parameter int OP_W     = OP_W_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  output logic                full,
  output logic [RS_ADDR:0]    count,
  input  logic                inst_valid,
  input  logic [OP_W-1:0]     inst_op,
  input  logic [ROB_ADDR-1:0] inst_rob_index,
  input  logic [XLEN-1:0]     inst_val1,
  input  logic [XLEN-1:0]     inst_val2,
  input  logic                inst_has_rely1,
  input  logic                inst_has_rely2,
  input  logic [ROB_ADDR-1:0] inst_rely1,
  input  logic [ROB_ADDR-1:0] inst_rely2,
  input  logic                rs_clear,
  input  logic                cdb_valid,
  input  logic [ROB_ADDR-1:0] cdb_rob_index,
  input  logic [XLEN-1:0]     cdb_value,
  output logic                alu_valid,
  output logic [OP_W-1:0]     alu_op,
  output logic [XLEN-1:0]     alu_rs1,
  output logic [XLEN-1:0]     alu_rs2,
  output logic [ROB_ADDR-1:0] alu_rob_index
);

  localparam int CNT_W = RS_ADDR + 1;

  // entry state: flags are reset, payload is only meaningful while busy
  logic [RS_SIZE-1:0]  r_busy, r_qj, r_qk;
  logic [OP_W-1:0]     r_op     [RS_SIZE];
  logic [ROB_ADDR-1:0] r_rob    [RS_SIZE];
  logic [ROB_ADDR-1:0] r_qj_tag [RS_SIZE];
  logic [ROB_ADDR-1:0] r_qk_tag [RS_SIZE];
  logic [XLEN-1:0]     r_vj     [RS_SIZE];
  logic [XLEN-1:0]     r_vk     [RS_SIZE];

  logic [RS_SIZE-1:0]  w_ready;
  logic                w_free_valid, w_sel_valid;
  logic [RS_ADDR-1:0]  w_free_idx, w_sel_idx;
  logic                w_alloc, w_issue;
  logic                w_bypass1, w_bypass2, w_wait1, w_wait2;
  logic [CNT_W-1:0]    w_count;

  assign full    = &r_busy;
  assign count   = w_count;
  assign w_ready = r_busy & ~r_qj & ~r_qk;

  // flush and stall both suppress every state-changing action
  assign w_alloc = inst_valid && !full && rdy_in && !rs_clear;
  assign w_issue = w_sel_valid && rdy_in && !rs_clear;

  // an operand whose producer is broadcasting right now is captured as ready
  assign w_bypass1 = inst_has_rely1 && cdb_valid && (inst_rely1 == cdb_rob_index);
  assign w_bypass2 = inst_has_rely2 && cdb_valid && (inst_rely2 == cdb_rob_index);
  assign w_wait1   = inst_has_rely1 && !w_bypass1;
  assign w_wait2   = inst_has_rely2 && !w_bypass2;

  // occupancy is derived from the registered busy vector only
  always_comb begin
    w_count = '0;
    for (int i = 0; i < RS_SIZE; i++) w_count = w_count + CNT_W'(r_busy[i]);
  end

  rs_prio_pick #(.N(RS_SIZE), .W(RS_ADDR)) u_free_pick (
    .req   (~r_busy),
    .valid (w_free_valid),
    .idx   (w_free_idx)
  );

`ifdef RS_AGE_ORDER_EN
  // r_age[i][j] = 1 means entry j was allocated before entry i
  logic [RS_SIZE-1:0] r_age [RS_SIZE];
  logic [RS_SIZE-1:0] w_issue_oh;

  assign w_sel_valid = |w_ready;
  assign w_issue_oh  = w_issue ? (RS_SIZE'(1) << w_sel_idx) : '0;

  // oldest ready entry: no other ready entry is older than it
  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i] && ((r_age[i] & w_ready) == '0)) w_sel_idx = RS_ADDR'(i);
    end
  end

  // row loaded with current occupants on allocate, column dropped on issue
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_age[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (rs_clear)
          r_age[i] <= '0;
        else if (w_alloc && (w_free_idx == RS_ADDR'(i)))
          r_age[i] <= r_busy & ~w_issue_oh;
        else
          r_age[i] <= r_age[i] & ~w_issue_oh;
      end
    end
  end
`else
  rs_prio_pick #(.N(RS_SIZE), .W(RS_ADDR)) u_ready_pick (
    .req   (w_ready),
    .valid (w_sel_valid),
    .idx   (w_sel_idx)
  );
`endif

  // entry payload: operand capture from CDB and writes on allocate
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rs_clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cdb_valid && r_busy[i] && r_qj[i] && (r_qj_tag[i] == cdb_rob_index))
          r_vj[i] <= cdb_value;
        if (cdb_valid && r_busy[i] && r_qk[i] && (r_qk_tag[i] == cdb_rob_index))
          r_vk[i] <= cdb_value;
        if (w_alloc && (w_free_idx == RS_ADDR'(i))) begin
          r_op[i]     <= inst_op;
          r_rob[i]    <= inst_rob_index;
          r_qj_tag[i] <= inst_rely1;
          r_qk_tag[i] <= inst_rely2;
          r_vj[i]     <= w_bypass1 ? cdb_value : inst_val1;
          r_vk[i]     <= w_bypass2 ? cdb_value : inst_val2;
        end
      end
    end
  end

  // entry flags and the registered ALU issue port
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy        <= '0;
      r_qj          <= '0;
      r_qk          <= '0;
      alu_valid     <= 1'b0;
      alu_op        <= '0;
      alu_rs1       <= '0;
      alu_rs2       <= '0;
      alu_rob_index <= '0;
    end else if (!rdy_in) begin
      alu_valid <= 1'b0;
    end else if (rs_clear) begin
      r_busy    <= '0;
      r_qj      <= '0;
      r_qk      <= '0;
      alu_valid <= 1'b0;
    end else begin
      alu_valid <= w_sel_valid;
      if (w_sel_valid) begin
        alu_op        <= r_op[w_sel_idx];
        alu_rs1       <= r_vj[w_sel_idx];
        alu_rs2       <= r_vk[w_sel_idx];
        alu_rob_index <= r_rob[w_sel_idx];
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (cdb_valid && r_busy[i] && r_qj[i] && (r_qj_tag[i] == cdb_rob_index))
          r_qj[i] <= 1'b0;
        if (cdb_valid && r_busy[i] && r_qk[i] && (r_qk_tag[i] == cdb_rob_index))
          r_qk[i] <= 1'b0;
        if (w_issue && (w_sel_idx == RS_ADDR'(i)))
          r_busy[i] <= 1'b0;
        if (w_alloc && (w_free_idx == RS_ADDR'(i))) begin
          r_busy[i] <= 1'b1;
          r_qj[i]   <= w_wait1;
          r_qk[i]   <= w_wait2;
        end
      end
    end
  end

  // free-pick valid duplicates !full; kept for readability of the pick
  logic w_unused;
  assign w_unused = w_free_valid;

endmodule

`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
// ============================================================================
// Module  : tb_rs_issue_queue
// Brief   : Self-checking bench for rs_issue_queue: directed scenarios plus a
//           randomized phase, all checked against an entry-list model that
//           follows the reservation-station rules (lowest free slot, oldest
//           or lowest-index ready issue depending on RS_AGE_ORDER_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_issue_queue;
  import rs_issue_queue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        full;
  logic [3:0]  count;
  logic        inst_valid;
  logic [5:0]  inst_op;
  logic [3:0]  inst_rob_index;
  logic [31:0] inst_val1, inst_val2;
  logic        inst_has_rely1, inst_has_rely2;
  logic [3:0]  inst_rely1, inst_rely2;
  logic        rs_clear;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_index;
  logic [31:0] cdb_value;
  logic        alu_valid;
  logic [5:0]  alu_op;
  logic [31:0] alu_rs1, alu_rs2;
  logic [3:0]  alu_rob_index;

  rs_issue_queue dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .full(full), .count(count),
    .inst_valid(inst_valid), .inst_op(inst_op), .inst_rob_index(inst_rob_index),
    .inst_val1(inst_val1), .inst_val2(inst_val2),
    .inst_has_rely1(inst_has_rely1), .inst_has_rely2(inst_has_rely2),
    .inst_rely1(inst_rely1), .inst_rely2(inst_rely2), .rs_clear(rs_clear),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rob_index(alu_rob_index)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;

  // reference model: one record per slot plus an allocation sequence number
  bit          mb  [8];
  bit          mw1 [8], mw2 [8];
  logic [5:0]  mop [8];
  logic [3:0]  mrob[8], mt1[8], mt2[8];
  logic [31:0] mv1 [8], mv2 [8];
  int          mseq[8];
  int          seqc;
  bit          ev;
  logic [5:0]  eop;
  logic [31:0] ers1, ers2;
  logic [3:0]  erob;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(mb[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mb[i] = 0; mw1[i] = 0; mw2[i] = 0;
    end
    seqc = 0; ev = 0; eop = '0; ers1 = '0; ers2 = '0; erob = '0;
  endtask

  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    int k = -1;
    int f = -1;
    if (!rdy_in) begin
      ev = 0;
      return;
    end
    if (rs_clear) begin
      for (int i = 0; i < 8; i++) mb[i] = 0;
      ev = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      if (mb[i] && !mw1[i] && !mw2[i]) begin
`ifdef RS_AGE_ORDER_EN
        if (k < 0 || mseq[i] < mseq[k]) k = i;
`else
        if (k < 0) k = i;
`endif
      end
      if (!mb[i] && f < 0) f = i;
    end
    if (k >= 0) begin
      ev = 1; eop = mop[k]; ers1 = mv1[k]; ers2 = mv2[k]; erob = mrob[k];
      mb[k] = 0;
    end else begin
      ev = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (mb[i] && cdb_valid && mw1[i] && mt1[i] == cdb_rob_index) begin
        mv1[i] = cdb_value; mw1[i] = 0;
      end
      if (mb[i] && cdb_valid && mw2[i] && mt2[i] == cdb_rob_index) begin
        mv2[i] = cdb_value; mw2[i] = 0;
      end
    end
    if (inst_valid && f >= 0) begin
      mb[f] = 1; mop[f] = inst_op; mrob[f] = inst_rob_index;
      mt1[f] = inst_rely1; mt2[f] = inst_rely2;
      mw1[f] = inst_has_rely1 && !(cdb_valid && inst_rely1 == cdb_rob_index);
      mw2[f] = inst_has_rely2 && !(cdb_valid && inst_rely2 == cdb_rob_index);
      mv1[f] = (inst_has_rely1 && !mw1[f]) ? cdb_value : inst_val1;
      mv2[f] = (inst_has_rely2 && !mw2[f]) ? cdb_value : inst_val2;
      mseq[f] = seqc++;
    end
  endtask

  // one clock: model step, edge, then compare every output
  task automatic cycle();
    model_step();
    @(posedge clk_in);
    #1;
    chk("alu_valid", alu_valid, ev);
    chk("alu_op", alu_op, eop);
    chk("alu_rs1", alu_rs1, ers1);
    chk("alu_rs2", alu_rs2, ers2);
    chk("alu_rob_index", alu_rob_index, erob);
    chk("count", count, mcount());
    chk("full", full, mcount() == 8);
  endtask

  task automatic idle();
    inst_valid = 0; inst_has_rely1 = 0; inst_has_rely2 = 0;
    cdb_valid = 0; rs_clear = 0; rdy_in = 1;
  endtask

  task automatic alloc(input logic [5:0] op, input logic [3:0] rob,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic h1, input logic [3:0] r1,
                       input logic h2, input logic [3:0] r2);
    inst_valid = 1; inst_op = op; inst_rob_index = rob;
    inst_val1 = v1; inst_val2 = v2;
    inst_has_rely1 = h1; inst_rely1 = r1;
    inst_has_rely2 = h2; inst_rely2 = r2;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
    cdb_valid = 1; cdb_rob_index = tag; cdb_value = val;
  endtask

  initial begin
    rst_n_in = 0; idle();
    inst_op = '0; inst_rob_index = '0; inst_val1 = '0; inst_val2 = '0;
    inst_rely1 = '0; inst_rely2 = '0; cdb_rob_index = '0; cdb_value = '0;
    model_reset();

    // reset state held
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_alu_valid", alu_valid, 0);
    rst_n_in = 1;
    repeat (5) cycle();

    // independent op issues two edges after allocate
    alloc(ALU_ADD, 4'd2, 32'd3, 32'd4, 0, 4'd0, 0, 4'd0);
    cycle();
    idle();
    cycle();
    chk("t2_valid", alu_valid, 1);
    chk("t2_rs1", alu_rs1, 3);
    chk("t2_rs2", alu_rs2, 4);
    chk("t2_rob", alu_rob_index, 2);
    chk("t2_count", count, 0);
    cycle();

    // dependent op woken by a later CDB broadcast
    alloc(ALU_SUB, 4'd3, 32'hdead, 32'd7, 1, 4'd5, 0, 4'd0);
    cycle();
    idle();
    cycle(); cycle();
    cdb(4'd5, 32'h10);
    cycle();
    idle();
    cycle();
    chk("t3_valid", alu_valid, 1);
    chk("t3_rs1", alu_rs1, 32'h10);
    chk("t3_rs2", alu_rs2, 7);

    // same dependency resolved by the CDB in the allocate cycle
    alloc(ALU_OR, 4'd6, 32'hbeef, 32'd9, 1, 4'd5, 0, 4'd0);
    cdb(4'd5, 32'h20);
    cycle();
    idle();
    cycle();
    chk("t3b_valid", alu_valid, 1);
    chk("t3b_rs1", alu_rs1, 32'h20);
    cycle();

    // fill all slots waiting on tag 7, extra request ignored, then drain
    for (int i = 0; i < 8; i++) begin
      alloc(ALU_XOR, 4'(i), 32'(i), 32'(i + 100), 1, 4'd7, 0, 4'd0);
      cycle();
    end
    chk("t4_full", full, 1);
    alloc(ALU_AND, 4'd15, 32'd1, 32'd1, 0, 4'd0, 0, 4'd0);
    cycle();
    idle();
    cdb(4'd7, 32'h77);
    cycle();
    idle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("t4_issue_valid", alu_valid, 1);
      chk("t4_issue_rob", alu_rob_index, 32'(i));
      chk("t4_issue_rs1", alu_rs1, 32'h77);
    end
    cycle();

    // flush overrides a same-cycle CDB hit
    for (int i = 0; i < 4; i++) begin
      alloc(ALU_ADD, 4'(i), 32'd0, 32'd0, 1, 4'd8, 0, 4'd0);
      cycle();
    end
    idle();
    rs_clear = 1;
    cdb(4'd8, 32'h88);
    cycle();
    chk("t5_count", count, 0);
    chk("t5_valid", alu_valid, 0);
    idle();
    repeat (3) cycle();

    // age ordering: slot 3 older than re-used slot 1, both woken together
    alloc(ALU_ADD, 4'd0, 32'd0, 32'd0, 1, 4'd12, 0, 4'd0); cycle();
    alloc(ALU_ADD, 4'd1, 32'd1, 32'd1, 1, 4'd13, 0, 4'd0); cycle();
    alloc(ALU_ADD, 4'd2, 32'd2, 32'd2, 1, 4'd12, 0, 4'd0); cycle();
    alloc(ALU_ADD, 4'd3, 32'd3, 32'd3, 1, 4'd11, 0, 4'd0); cycle();
    idle(); cdb(4'd13, 32'h13); cycle();
    idle(); cycle();
    alloc(ALU_SUB, 4'd9, 32'd9, 32'd9, 1, 4'd11, 0, 4'd0); cycle();
    idle(); cdb(4'd11, 32'h11); cycle();
    idle(); rdy_in = 0; cycle();
    chk("t6_stall_valid", alu_valid, 0);
    idle(); cycle();
    chk("t6_first_valid", alu_valid, 1);
`ifdef RS_AGE_ORDER_EN
    chk("t6_first_rob", alu_rob_index, 3);
`else
    chk("t6_first_rob", alu_rob_index, 9);
`endif
    cycle();
    cdb(4'd12, 32'h12); cycle();
    idle(); repeat (4) cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      rdy_in   = ($urandom_range(0, 9) != 0);
      rs_clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) cdb(4'($urandom_range(0, 3)), $urandom);
      if (mcount() < 8 && $urandom_range(0, 1) == 1)
        alloc(6'($urandom_range(0, 9)), 4'($urandom_range(0, 15)), $urandom, $urandom,
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
      cycle();
    end
    idle(); cycle();

    // asynchronous reset in the middle of a cycle
    alloc(ALU_ADD, 4'd4, 32'd1, 32'd2, 0, 4'd0, 0, 4'd0); cycle();
    alloc(ALU_ADD, 4'd5, 32'd1, 32'd2, 1, 4'd15, 0, 4'd0); cycle();
    idle();
    #2 rst_n_in = 0;
    #1;
    chk("arst_valid", alu_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_full", full, 0);
    chk("arst_op", alu_op, 0);
    chk("arst_rs1", alu_rs1, 0);
    chk("arst_rob", alu_rob_index, 0);
    @(posedge clk_in);
    #1 rst_n_in = 1;
    model_reset();
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
